// File: rtl/alu_issue_if.sv
// Instruction handshake, ALU operand/select bus and status signals shared
// between alu_issue_ctrl (master) and the CPU sequencer plus ALU (slave).
interface alu_issue_if #(
   parameter int DATA_W = 8
);
   logic              instr_valid;
   logic              instr_ready;
   logic [19:0]       instr;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [3:0]        alu_sel;
   logic [DATA_W-1:0] alu_out;
   logic              alu_carry;
   logic              done;
   logic              err;
   logic              flag_c;
   logic              flag_z;

   modport master (
      input  instr_valid, instr, alu_out, alu_carry,
      output instr_ready, alu_a, alu_b, alu_sel, done, err, flag_c, flag_z
   );

   modport slave (
      output instr_valid, instr, alu_out, alu_carry,
      input  instr_ready, alu_a, alu_b, alu_sel, done, err, flag_c, flag_z
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes one instruction per handshake, drives the
// external ALU from a 4-entry register file and writes the result back.
// Optional macro ALU_ISSUE_PIPE_EN: also accept a new instruction in WB,
// giving one instruction per 2 cycles instead of one per 3.
module alu_issue_ctrl #(
   parameter int DATA_W = 8,
   parameter int NREG   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_issue_if.master       bus,
   input  logic [1:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WB} state_t;

   localparam logic [3:0] OP_ADD        = 4'd0;
   localparam logic [3:0] OP_DIV        = 4'd3;
   localparam logic [3:0] OP_LAST_LEGAL = 4'd13;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_regs [NREG];
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [3:0]        r_alu_sel;     // doubles as the latched opcode
   logic [1:0]        r_rd;
   logic              r_wb_ok;       // result of the retire decision at E1
   logic              r_flag_c;
   logic              r_flag_z;

   // Instruction field decode
   logic [3:0]        w_op;
   logic [1:0]        w_rd;
   logic [1:0]        w_rs1;
   logic [1:0]        w_rs2;
   logic              w_use_imm;
   logic [DATA_W-1:0] w_imm;
   logic              w_unused_bit;
   logic              w_ready;
   logic              w_accept;
   logic              w_write_ok;

   assign w_op         = bus.instr[19:16];
   assign w_rd         = bus.instr[15:14];
   assign w_rs1        = bus.instr[13:12];
   assign w_use_imm    = bus.instr[11];
   assign w_unused_bit = bus.instr[10];
   assign w_rs2        = bus.instr[9:8];
   assign w_imm        = bus.instr[7:0];

`ifdef ALU_ISSUE_PIPE_EN
   assign w_ready = (r_state == ST_IDLE) || (r_state == ST_WB);
`else
   assign w_ready = (r_state == ST_IDLE);
`endif
   assign w_accept = bus.instr_valid && w_ready;

   // Retire with writeback only for legal ops that are not a divide by zero
   assign w_write_ok = (r_alu_sel <= OP_LAST_LEGAL) &&
                       !((r_alu_sel == OP_DIV) && (r_alu_b == '0));

   // State register
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and retire pulses
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      w_state_nxt = r_state;
      bus.done    = 1'b0;
      bus.err     = 1'b0;
      case (r_state)
         ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
         ST_ISSUE: w_state_nxt = ST_WB;
         ST_WB: begin
            bus.done    = r_wb_ok;
            bus.err     = !r_wb_ok;
            w_state_nxt = w_accept ? ST_ISSUE : ST_IDLE;
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Operand capture at E0, writeback and flag update at E1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the register file is only four words and must read zero
         // after reset, so it is cleared here like ordinary flops.
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_sel <= 4'b0000;
         r_rd      <= 2'd0;
         r_wb_ok   <= 1'b0;
         r_flag_c  <= 1'b0;
         r_flag_z  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_alu_a   <= r_regs[w_rs1];
            r_alu_b   <= w_use_imm ? w_imm : r_regs[w_rs2];
            r_alu_sel <= w_op;
            r_rd      <= w_rd;
         end
         if (r_state == ST_ISSUE) begin
            r_wb_ok <= w_write_ok;
            if (w_write_ok) begin
               r_regs[r_rd] <= bus.alu_out;
               r_flag_z     <= (bus.alu_out == '0);
               if (r_alu_sel == OP_ADD) r_flag_c <= bus.alu_carry;
            end
         end
      end
   end

   assign bus.instr_ready = w_ready;
   assign bus.alu_a       = r_alu_a;
   assign bus.alu_b       = r_alu_b;
   assign bus.alu_sel     = r_alu_sel;
   assign bus.flag_c      = r_flag_c;
   assign bus.flag_z      = r_flag_z;
   assign dbg_data        = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a table of single instructions with
// hand-computed results, then reset-mid-op and back-to-back throughput runs.
module tb_alu_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_addr = 2'd0;
   logic [7:0] dbg_data;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_fail = 0;

   alu_issue_if #(.DATA_W(8)) bus ();

   alu_issue_ctrl #(.DATA_W(8), .NREG(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference ALU attached to the operand bus
   always_comb begin
      logic [8:0] sum;
      sum           = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      bus.alu_carry = 1'b0;
      case (bus.alu_sel)
         4'h0: begin bus.alu_out = sum[7:0]; bus.alu_carry = sum[8]; end
         4'h1: bus.alu_out = bus.alu_a - bus.alu_b;
         4'h2: bus.alu_out = bus.alu_a & bus.alu_b;
         4'h3: bus.alu_out = (bus.alu_b == 8'h00) ? 8'hFF : bus.alu_a / bus.alu_b;
         4'h4: bus.alu_out = bus.alu_a | bus.alu_b;
         4'h5: bus.alu_out = bus.alu_a ^ bus.alu_b;
         4'h6: bus.alu_out = {bus.alu_a[6:0], bus.alu_a[7]};
         4'h7: bus.alu_out = {bus.alu_a[0], bus.alu_a[7:1]};
         4'h8: bus.alu_out = bus.alu_a << 1;
         4'h9: bus.alu_out = bus.alu_a >> 1;
         4'hA: bus.alu_out = ~bus.alu_a;
         4'hB: bus.alu_out = ~(bus.alu_a | bus.alu_b);
         4'hC: bus.alu_out = ~(bus.alu_a & bus.alu_b);
         4'hD: bus.alu_out = bus.alu_b;
         default: bus.alu_out = 8'h5A;
      endcase
   end

   typedef struct {
      logic [19:0] ins;
      logic [7:0]  exp_a;
      logic [7:0]  exp_b;
      logic [1:0]  rd;
      logic [7:0]  exp_rd;
      logic        exp_done;
      logic        exp_c;
      logic        exp_z;
   } vec_t;

   vec_t vecs [12];

   function automatic logic [19:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic use_imm,
                                       input logic [1:0] rs2, input logic [7:0] imm);
      return {op, rd, rs1, use_imm, 1'b0, rs2, imm};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_reg(input string name, input logic [1:0] addr, input logic [7:0] exp);
      dbg_addr = addr;
      #1;
      check(name, {24'h0, dbg_data}, {24'h0, exp});
   endtask

   // Present an instruction and return #1 after the accepting edge (E0)
   task automatic send(input logic [19:0] ins);
      int n;
      n = 0;
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr       = ins;
      while (!bus.instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("send_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
   endtask

   initial begin
      int hs [4];
      int nhs;
      int ndone;
      logic bad;

      bus.instr_valid = 1'b0;
      bus.instr       = '0;

      vecs[0]  = '{enc(4'h0, 2'd1, 2'd0, 1'b1, 2'd0, 8'h7F), 8'h00, 8'h7F, 2'd1, 8'h7F, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{enc(4'h0, 2'd2, 2'd1, 1'b1, 2'd0, 8'h81), 8'h7F, 8'h81, 2'd2, 8'h00, 1'b1, 1'b1, 1'b1};
      vecs[2]  = '{enc(4'h0, 2'd1, 2'd1, 1'b1, 2'd0, 8'h02), 8'h7F, 8'h02, 2'd1, 8'h81, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{enc(4'h0, 2'd0, 2'd1, 1'b1, 2'd0, 8'h80), 8'h81, 8'h80, 2'd0, 8'h01, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{enc(4'h6, 2'd3, 2'd1, 1'b1, 2'd0, 8'h00), 8'h81, 8'h00, 2'd3, 8'h03, 1'b1, 1'b1, 1'b0};
      vecs[5]  = '{enc(4'hB, 2'd2, 2'd1, 1'b1, 2'd0, 8'h00), 8'h81, 8'h00, 2'd2, 8'h7E, 1'b1, 1'b1, 1'b0};
      vecs[6]  = '{enc(4'h3, 2'd3, 2'd1, 1'b1, 2'd0, 8'h00), 8'h81, 8'h00, 2'd3, 8'h03, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{enc(4'hF, 2'd3, 2'd1, 1'b1, 2'd0, 8'h05), 8'h81, 8'h05, 2'd3, 8'h03, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{enc(4'h3, 2'd0, 2'd1, 1'b1, 2'd0, 8'h10), 8'h81, 8'h10, 2'd0, 8'h08, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{enc(4'h0, 2'd1, 2'd1, 1'b0, 2'd3, 8'hAA), 8'h81, 8'h03, 2'd1, 8'h84, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{enc(4'hD, 2'd3, 2'd0, 1'b1, 2'd0, 8'h00), 8'h08, 8'h00, 2'd3, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{enc(4'hE, 2'd3, 2'd1, 1'b1, 2'd0, 8'hFF), 8'h84, 8'hFF, 2'd3, 8'h00, 1'b0, 1'b0, 1'b1};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ready", {31'h0, bus.instr_ready}, 32'd1);
      check("rst_done",  {31'h0, bus.done}, 32'd0);
      check("rst_err",   {31'h0, bus.err}, 32'd0);
      check("rst_sel",   {28'h0, bus.alu_sel}, 32'd0);
      check("rst_a",     {24'h0, bus.alu_a}, 32'd0);
      check("rst_b",     {24'h0, bus.alu_b}, 32'd0);
      check("rst_fc",    {31'h0, bus.flag_c}, 32'd0);
      check("rst_fz",    {31'h0, bus.flag_z}, 32'd0);
      for (int r = 0; r < 4; r++) check_reg("rst_reg", 2'(r), 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven single instructions
      for (int i = 0; i < 12; i++) begin
         send(vecs[i].ins);
         @(negedge clk);   // ISSUE
         check($sformatf("v%0d_alu_a", i), {24'h0, bus.alu_a}, {24'h0, vecs[i].exp_a});
         check($sformatf("v%0d_alu_b", i), {24'h0, bus.alu_b}, {24'h0, vecs[i].exp_b});
         check($sformatf("v%0d_alu_sel", i), {28'h0, bus.alu_sel}, {28'h0, vecs[i].ins[19:16]});
         check($sformatf("v%0d_issue_pulse", i), {30'h0, bus.done, bus.err}, 32'd0);
         @(negedge clk);   // WB
         check($sformatf("v%0d_done", i), {31'h0, bus.done}, {31'h0, vecs[i].exp_done});
         check($sformatf("v%0d_err", i), {31'h0, bus.err}, {31'h0, !vecs[i].exp_done});
         check($sformatf("v%0d_flag_c", i), {31'h0, bus.flag_c}, {31'h0, vecs[i].exp_c});
         check($sformatf("v%0d_flag_z", i), {31'h0, bus.flag_z}, {31'h0, vecs[i].exp_z});
         check_reg($sformatf("v%0d_rd", i), vecs[i].rd, vecs[i].exp_rd);
         @(negedge clk);   // back in IDLE
         check($sformatf("v%0d_pulse_end", i), {30'h0, bus.done, bus.err}, 32'd0);
         check($sformatf("v%0d_hold_a", i), {24'h0, bus.alu_a}, {24'h0, vecs[i].exp_a});
      end
      check_reg("final_reg0", 2'd0, 8'h08);
      check_reg("final_reg1", 2'd1, 8'h84);
      check_reg("final_reg2", 2'd2, 8'h7E);

      // Reset asserted while an ADD rd=3 is in ISSUE
      send(enc(4'h0, 2'd3, 2'd1, 1'b1, 2'd0, 8'h01));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_ready", {31'h0, bus.instr_ready}, 32'd1);
      check("midrst_pulse", {30'h0, bus.done, bus.err}, 32'd0);
      check("midrst_sel",   {28'h0, bus.alu_sel}, 32'd0);
      check_reg("midrst_reg3", 2'd3, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done || bus.err || !bus.instr_ready) bad = 1'b1;
      end
      check("midrst_after_quiet", {31'h0, bad}, 32'd0);
      check_reg("midrst_after_reg3", 2'd3, 8'h00);

      // Back-to-back ADD reg1 += 1 with instr_valid held
      nhs   = 0;
      ndone = 0;
      @(negedge clk);
      bus.instr       = enc(4'h0, 2'd1, 2'd1, 1'b1, 2'd0, 8'h01);
      bus.instr_valid = 1'b1;
      for (int c = 0; c < 40 && nhs < 4; c++) begin
         if (c > 0) @(negedge clk);
         if (bus.done) ndone++;
         if (bus.instr_ready) begin
            hs[nhs] = cyc;
            nhs++;
         end
         @(posedge clk);
         #1;
         if (nhs == 4) bus.instr_valid = 1'b0;
      end
      bus.instr_valid = 1'b0;
      check("b2b_handshakes", nhs, 4);
      repeat (4) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      check("b2b_done_count", ndone, 4);
      check_reg("b2b_reg1", 2'd1, 8'h04);
      if (nhs == 4) begin
         for (int k = 1; k < 4; k++) begin
`ifdef ALU_ISSUE_PIPE_EN
            check($sformatf("b2b_gap%0d", k), hs[k] - hs[k-1], 2);
`else
            check($sformatf("b2b_gap%0d", k), hs[k] - hs[k-1], 3);
`endif
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
